// File: rtl/fir_decim_requant.sv
`default_nettype none
// fir_decim_requant: requantise the FIR sum to WORD_OUT bits (round-half-up, saturate),
// decimate by DECIM and buffer kept samples in a first-word-fall-through FIFO. Rev 1.0
module fir_decim_requant #(
  parameter int WORD_IN    = 17,
  parameter int WORD_OUT   = 8,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [WORD_IN-1:0]            Data_in,
  output logic [WORD_OUT-1:0]           out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          saturated
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0]    c_PH_LAST = PH_W'(DECIM - 1);
  localparam logic [WORD_IN:0]   c_HALF    = (WORD_IN+1)'(1) << (SHIFT - 1);
  localparam logic [WORD_IN:0]   c_MAX     = (WORD_IN+1)'((1 << WORD_OUT) - 1);
  localparam logic [PTR_W:0]     c_DEPTH   = (PTR_W+1)'(FIFO_DEPTH);

  // Stage 1: rounding and clipping
  logic [WORD_IN:0]    w_sum;
  logic [WORD_IN:0]    w_shr;
  logic                w_clip;
  logic [WORD_OUT-1:0] w_q;

  assign w_sum  = {1'b0, Data_in} + c_HALF;
  assign w_shr  = w_sum >> SHIFT;
  assign w_clip = (w_shr > c_MAX);
  assign w_q    = w_clip ? c_MAX[WORD_OUT-1:0] : w_shr[WORD_OUT-1:0];

  logic [PH_W-1:0]     r_phase;
  logic                r_s1_valid;
  logic [WORD_OUT-1:0] r_s1_data;
  logic                r_sat;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_phase    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_s1_valid <= in_valid && (r_phase == '0);
      if (in_valid) begin
        r_s1_data <= w_q;
        r_phase   <= (r_phase == c_PH_LAST) ? '0 : r_phase + 1'b1;
        if (w_clip) r_sat <= 1'b1;
      end
    end
  end

  // Stage 2: FWFT FIFO; a full FIFO still accepts a push when it is popped in the same cycle
  logic [WORD_OUT-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_level;
  logic                r_ovf;
  logic                w_pop;
  logic                w_full;
  logic                w_push;

  assign out_valid = (r_level != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_full    = (r_level == c_DEPTH);
  assign w_push    = r_s1_valid && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s1_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      if (r_s1_valid && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_level = r_level;
  assign overflow   = r_ovf;
  assign saturated  = r_sat;

endmodule
`default_nettype wire
